pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Measures the complementary gate-drive pair (C_1 top, C_2 bottom) as driven onto the GPIO pins, and reports:
  - switching period;
  - C_1 and C_2 on-times;
  - both dead times.
- Detects shoot-through (both high) and sequence faults.
- Sits on the feedback side of the DPWM/dead-time chain. Results feed closed-loop verification and the protection logic (drives EN low on fault).

Parameters:
- W, 10, width of all count outputs (matches maxcount width).
- MAX_COUNT, 1023, saturation/timeout limit for any single interval counter; must be at most 2^W-1.

Ports:
- clk  input  1  system clock (50 MHz, 20 ns).
- reset  input  1  asynchronous, active-high reset.
- EN  input  1  measurement enable; low = idle.
- C_1  input  1  top gate signal, asynchronous to clk.
- C_2  input  1  bottom gate signal, asynchronous to clk.
- clear_faults  input  1  synchronous pulse; clears sticky fault flags.
- period  output  W  cycles between consecutive C_1 rising edges.
- on_c1  output  W  cycles C_1 high in last period.
- on_c2  output  W  cycles C_2 high in last period.
- dt_12  output  W  cycles both low, from C_1 fall to C_2 rise.
- dt_21  output  W  cycles both low, from C_2 fall to C_1 rise.
- meas_valid  output  1  one-cycle pulse when the five outputs above update.
- overlap_fault  output  1  sticky; C_1 and C_2 both high seen.
- seq_fault  output  1  sticky; illegal edge order seen.
- timeout  output  1  sticky; an interval reached MAX_COUNT.

Behaviour:
- Input synchronisation:
  - C_1 and C_2 each pass through a 2-flop synchroniser, giving s1 and s2.
  - One further register holds the previous values for edge detection.
  - Pin-to-detection latency is 3 clk cycles. All interval semantics below refer to s1/s2.
- Reset: all outputs 0; state IDLE; all counters 0.
- State machine:
  - IDLE: entered when EN=0. Counters held at 0; outputs keep their last values. When EN=1, go to SYNC.
  - SYNC: wait for an s1 rising edge; then go to HI1 with counters cleared. No measurement is published from SYNC.
  - HI1 (s1=1, s2=0): count on_c1.
    - s1 falls with s2=0: go to DT12.
    - s1 falls with s2 rising in the same cycle: dt_12=0, go to HI2.
  - DT12 (both low): count dt_12.
    - s2 rises: go to HI2.
    - s1 rises instead: seq_fault, go to SYNC.
  - HI2 (s2=1, s1=0): count on_c2.
    - s2 falls: go to DT21.
    - Simultaneous s2 fall and s1 rise: dt_21=0; publish.
  - DT21 (both low): count dt_21.
    - s1 rises: publish, go to HI1 with counters cleared.
    - s2 rises instead: seq_fault, go to SYNC.
- Counting rule: each cycle spent in a state increments that state's counter by 1, including the first cycle after the entry edge. period is the sum of the four interval counters.
- Publish: on the cycle the s1 rising edge is detected, register period, on_c1, on_c2, dt_12 and dt_21, and pulse meas_valid high for exactly that cycle. The new period's counting starts the same cycle at 1 (the HI1 cycle).
- Overlap:
  - Any cycle with s1=s2=1 sets overlap_fault and forces SYNC, regardless of state.
  - SYNC additionally waits until both s1 and s2 are low before accepting an s1 rise.
- Timeout: any interval counter reaching MAX_COUNT saturates, sets timeout, and forces SYNC. This covers a stuck gate.
- Sticky flags: clear only on reset or clear_faults. If a fault condition and clear_faults occur in the same cycle, the set wins.
- Aborted measurements:
  - EN falling mid-period aborts the measurement: no meas_valid, go to IDLE.
  - Asynchronous reset mid-period returns to the reset values above immediately.
- Arithmetic: all counters are unsigned W-bit. period never wraps; it saturates at MAX_COUNT via timeout.

Test Plan:
- Nominal 140 kHz pair (C_1 high 200, dead 3, C_2 high 150, dead 5 cycles, repeating), EN=1 -> from the second C_1 rise onward, meas_valid once per 358 cycles with period=358, on_c1=200, dt_12=3, on_c2=150, dt_21=5; no faults.
- Zero dead time (C_1 high 207, C_2 high 151, edges coincident) -> dt_12=0, dt_21=0, period=358; no seq_fault.
- C_2 driven high for 2 cycles during C_1 high -> overlap_fault=1 about 3 cycles later, no meas_valid for that period. Measurements resume after the next clean C_1 rise plus one full period. Flag stays set until a clear_faults pulse, which clears it.
- C_1 held high indefinitely -> timeout=1 after 1023 HI1 cycles; no meas_valid. Releasing C_1 restores normal operation from SYNC.
- Two C_1 pulses with no C_2 between them -> seq_fault=1; outputs keep their last valid values.
- Assert reset mid-HI2 -> all outputs 0 asynchronously. Apply EN=0 mid-period -> no meas_valid; the first valid result after EN=1 arrives at the second C_1 rise.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - gate-drive pair capture: period, on-times, dead times, fault flags
module pwm_capture #(
    parameter int W         = 10,
    parameter int MAX_COUNT = 1023
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         c1_i,
    input  logic         c2_i,
    input  logic         clear_faults_i,
    output logic [W-1:0] period_o,
    output logic [W-1:0] on_c1_o,
    output logic [W-1:0] on_c2_o,
    output logic [W-1:0] dt_12_o,
    output logic [W-1:0] dt_21_o,
    output logic         meas_valid_o,
    output logic         overlap_fault_o,
    output logic         seq_fault_o,
    output logic         timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_HI1, ST_DT12, ST_HI2, ST_DT21
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] MAX_C = W'(MAX_COUNT);

    logic c1_meta_q, s1_q, p1_q;
    logic c2_meta_q, s2_q, p2_q;
    logic rise1, fall1, rise2, fall2;

    state_t state_q, state_d;
    logic armed_q, armed_d;
    logic [W-1:0] per_q, per_d, on1_q, on1_d, dt12_q, dt12_d, on2_q, on2_d, dt21_q, dt21_d;
    logic [W-1:0] period_q, on_c1_q, on_c2_q, dt_12_q, dt_21_q;
    logic meas_valid_q, overlap_q, seq_q, tmo_q;
    logic publish, start, counting, set_ovl, set_seq, set_tmo;

    assign rise1 = s1_q & ~p1_q;
    assign fall1 = ~s1_q & p1_q;
    assign rise2 = s2_q & ~p2_q;
    assign fall2 = ~s2_q & p2_q;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        per_d    = per_q;
        on1_d    = on1_q;
        dt12_d   = dt12_q;
        on2_d    = on2_q;
        dt21_d   = dt21_q;
        publish  = 1'b0;
        start    = 1'b0;
        counting = 1'b0;
        set_ovl  = 1'b0;
        set_seq  = 1'b0;
        set_tmo  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_SYNC;
                armed_d = 1'b0;
            end
            ST_SYNC: begin
                if (!s1_q && !s2_q) armed_d = 1'b1;
                if (rise1 && !s2_q && armed_q) start = 1'b1;
            end
            ST_HI1: begin
                counting = 1'b1;
                if (fall1 && rise2) begin
                    on2_d   = ONE;
                    state_d = ST_HI2;
                end else if (fall1) begin
                    dt12_d  = ONE;
                    state_d = ST_DT12;
                end else begin
                    on1_d = on1_q + ONE;
                end
            end
            ST_DT12: begin
                if (rise1) begin
                    set_seq = 1'b1;
                end else begin
                    counting = 1'b1;
                    if (rise2) begin
                        on2_d   = ONE;
                        state_d = ST_HI2;
                    end else begin
                        dt12_d = dt12_q + ONE;
                    end
                end
            end
            ST_HI2: begin
                if (fall2 && rise1) begin
                    publish = 1'b1;
                    start   = 1'b1;
                end else begin
                    counting = 1'b1;
                    if (fall2) begin
                        dt21_d  = ONE;
                        state_d = ST_DT21;
                    end else begin
                        on2_d = on2_q + ONE;
                    end
                end
            end
            ST_DT21: begin
                if (rise1) begin
                    publish = 1'b1;
                    start   = 1'b1;
                end else if (rise2) begin
                    set_seq = 1'b1;
                end else begin
                    counting = 1'b1;
                    dt21_d   = dt21_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The running period bounds every interval counter, so it alone triggers timeout.
        if (counting) begin
            per_d = per_q + ONE;
            if (per_q >= MAX_C - ONE) set_tmo = 1'b1;
        end

        if (start) begin
            state_d = ST_HI1;
            per_d   = ONE;
            on1_d   = ONE;
            dt12_d  = '0;
            on2_d   = '0;
            dt21_d  = '0;
        end

        if (s1_q && s2_q) begin
            set_ovl = 1'b1;
            set_seq = 1'b0;
            publish = 1'b0;
        end

        if (set_ovl || set_seq || set_tmo) begin
            state_d = ST_SYNC;
            armed_d = 1'b0;
        end

        if (!en_i) begin
            state_d = ST_IDLE;
            armed_d = 1'b0;
            per_d   = '0;
            on1_d   = '0;
            dt12_d  = '0;
            on2_d   = '0;
            dt21_d  = '0;
            publish = 1'b0;
            set_ovl = 1'b0;
            set_seq = 1'b0;
            set_tmo = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c1_meta_q    <= 1'b0;
            s1_q         <= 1'b0;
            p1_q         <= 1'b0;
            c2_meta_q    <= 1'b0;
            s2_q         <= 1'b0;
            p2_q         <= 1'b0;
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            per_q        <= '0;
            on1_q        <= '0;
            dt12_q       <= '0;
            on2_q        <= '0;
            dt21_q       <= '0;
            period_q     <= '0;
            on_c1_q      <= '0;
            on_c2_q      <= '0;
            dt_12_q      <= '0;
            dt_21_q      <= '0;
            meas_valid_q <= 1'b0;
            overlap_q    <= 1'b0;
            seq_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            c1_meta_q    <= c1_i;
            s1_q         <= c1_meta_q;
            p1_q         <= s1_q;
            c2_meta_q    <= c2_i;
            s2_q         <= c2_meta_q;
            p2_q         <= s2_q;
            state_q      <= state_d;
            armed_q      <= armed_d;
            per_q        <= per_d;
            on1_q        <= on1_d;
            dt12_q       <= dt12_d;
            on2_q        <= on2_d;
            dt21_q       <= dt21_d;
            meas_valid_q <= publish;
            if (publish) begin
                period_q <= per_q;
                on_c1_q  <= on1_q;
                on_c2_q  <= on2_q;
                dt_12_q  <= dt12_q;
                dt_21_q  <= dt21_q;
            end
            // A fault seen in the same cycle as clear_faults keeps its flag set.
            overlap_q <= set_ovl | (overlap_q & ~clear_faults_i);
            seq_q     <= set_seq | (seq_q & ~clear_faults_i);
            tmo_q     <= set_tmo | (tmo_q & ~clear_faults_i);
        end
    end

    assign period_o        = period_q;
    assign on_c1_o         = on_c1_q;
    assign on_c2_o         = on_c2_q;
    assign dt_12_o         = dt_12_q;
    assign dt_21_o         = dt_21_q;
    assign meas_valid_o    = meas_valid_q;
    assign overlap_fault_o = overlap_q;
    assign seq_fault_o     = seq_q;
    assign timeout_o       = tmo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       c1 = 1'b0;
    logic       c2 = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] period, on_c1, on_c2, dt_12, dt_21;
    logic       meas_valid, ovl, seq, tmo;

    int vectors = 0;
    int misses = 0;

    int pulses = 0;
    int cyc = 0;
    int last_cyc = 0;
    int gap = 0;
    int lp = 0, l_on1 = 0, l_on2 = 0, l_dt12 = 0, l_dt21 = 0;

    pwm_capture #(.W(10), .MAX_COUNT(1023)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .c1_i            (c1),
        .c2_i            (c2),
        .clear_faults_i  (clr),
        .period_o        (period),
        .on_c1_o         (on_c1),
        .on_c2_o         (on_c2),
        .dt_12_o         (dt_12),
        .dt_21_o         (dt_21),
        .meas_valid_o    (meas_valid),
        .overlap_fault_o (ovl),
        .seq_fault_o     (seq),
        .timeout_o       (tmo)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (meas_valid === 1'b1) begin
            pulses   = pulses + 1;
            gap      = cyc - last_cyc;
            last_cyc = cyc;
            lp       = int'(period);
            l_on1    = int'(on_c1);
            l_on2    = int'(on_c2);
            l_dt12   = int'(dt_12);
            l_dt21   = int'(dt_21);
        end
    end

    task automatic drive(input logic a, input logic b, input int n);
        c1 = a;
        c2 = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic nominal_period();
        drive(1'b1, 1'b0, 200);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 150);
        drive(1'b0, 1'b0, 5);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        c1  = 1'b0;
        c2  = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (period !== 10'd0) begin $display("FAIL reset_period: got %0d expected 0", period); misses++; end
        vectors++; if (on_c1 !== 10'd0) begin $display("FAIL reset_on_c1: got %0d expected 0", on_c1); misses++; end
        vectors++; if (meas_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b expected 0", meas_valid); misses++; end
        vectors++; if ({ovl, seq, tmo} !== 3'b000) begin $display("FAIL reset_flags: got %b expected 000", {ovl, seq, tmo}); misses++; end
    endtask

    task automatic test_nominal();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        repeat (3) nominal_period();
        drive(1'b1, 1'b0, 10);
        vectors++; if (pulses - base !== 3) begin $display("FAIL nom_count: got %0d expected 3", pulses - base); misses++; end
        vectors++; if (lp !== 358) begin $display("FAIL nom_period: got %0d expected 358", lp); misses++; end
        vectors++; if (l_on1 !== 200) begin $display("FAIL nom_on_c1: got %0d expected 200", l_on1); misses++; end
        vectors++; if (l_dt12 !== 3) begin $display("FAIL nom_dt_12: got %0d expected 3", l_dt12); misses++; end
        vectors++; if (l_on2 !== 150) begin $display("FAIL nom_on_c2: got %0d expected 150", l_on2); misses++; end
        vectors++; if (l_dt21 !== 5) begin $display("FAIL nom_dt_21: got %0d expected 5", l_dt21); misses++; end
        vectors++; if (gap !== 358) begin $display("FAIL nom_gap: got %0d expected 358", gap); misses++; end
        vectors++; if ({ovl, seq, tmo} !== 3'b000) begin $display("FAIL nom_flags: got %b expected 000", {ovl, seq, tmo}); misses++; end
    endtask

    task automatic test_zero_deadtime();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        repeat (3) begin
            drive(1'b1, 1'b0, 207);
            drive(1'b0, 1'b1, 151);
        end
        drive(1'b1, 1'b0, 10);
        vectors++; if (pulses - base !== 3) begin $display("FAIL zdt_count: got %0d expected 3", pulses - base); misses++; end
        vectors++; if (lp !== 358) begin $display("FAIL zdt_period: got %0d expected 358", lp); misses++; end
        vectors++; if (l_on1 !== 207) begin $display("FAIL zdt_on_c1: got %0d expected 207", l_on1); misses++; end
        vectors++; if (l_on2 !== 151) begin $display("FAIL zdt_on_c2: got %0d expected 151", l_on2); misses++; end
        vectors++; if (l_dt12 !== 0) begin $display("FAIL zdt_dt_12: got %0d expected 0", l_dt12); misses++; end
        vectors++; if (l_dt21 !== 0) begin $display("FAIL zdt_dt_21: got %0d expected 0", l_dt21); misses++; end
        vectors++; if (seq !== 1'b0) begin $display("FAIL zdt_seq: got %0b expected 0", seq); misses++; end
    endtask

    task automatic test_overlap();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        nominal_period();
        drive(1'b1, 1'b0, 100);
        drive(1'b1, 1'b1, 2);
        vectors++; if (ovl !== 1'b0) begin $display("FAIL ovl_early: got %0b expected 0", ovl); misses++; end
        drive(1'b1, 1'b0, 1);
        vectors++; if (ovl !== 1'b1) begin $display("FAIL ovl_set: got %0b expected 1", ovl); misses++; end
        drive(1'b1, 1'b0, 97);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 150);
        drive(1'b0, 1'b0, 5);
        vectors++; if (pulses - base !== 1) begin $display("FAIL ovl_no_valid: got %0d expected 1", pulses - base); misses++; end
        nominal_period();
        nominal_period();
        drive(1'b1, 1'b0, 10);
        vectors++; if (pulses - base !== 3) begin $display("FAIL ovl_resume: got %0d expected 3", pulses - base); misses++; end
        vectors++; if (lp !== 358) begin $display("FAIL ovl_period: got %0d expected 358", lp); misses++; end
        vectors++; if (ovl !== 1'b1) begin $display("FAIL ovl_sticky: got %0b expected 1", ovl); misses++; end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++; if (ovl !== 1'b0) begin $display("FAIL ovl_clear: got %0b expected 0", ovl); misses++; end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        drive(1'b1, 1'b0, 1024);
        vectors++; if (tmo !== 1'b0) begin $display("FAIL tmo_early: got %0b expected 0", tmo); misses++; end
        drive(1'b1, 1'b0, 1);
        vectors++; if (tmo !== 1'b1) begin $display("FAIL tmo_set: got %0b expected 1", tmo); misses++; end
        vectors++; if (pulses - base !== 0) begin $display("FAIL tmo_no_valid: got %0d expected 0", pulses - base); misses++; end
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 5);
        nominal_period();
        nominal_period();
        drive(1'b1, 1'b0, 10);
        vectors++; if (pulses - base !== 2) begin $display("FAIL tmo_recover: got %0d expected 2", pulses - base); misses++; end
        vectors++; if (lp !== 358) begin $display("FAIL tmo_period: got %0d expected 358", lp); misses++; end
        vectors++; if (tmo !== 1'b1) begin $display("FAIL tmo_sticky: got %0b expected 1", tmo); misses++; end
    endtask

    task automatic test_seq_fault();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        nominal_period();
        drive(1'b1, 1'b0, 200);
        drive(1'b0, 1'b0, 3);
        vectors++; if (seq !== 1'b0) begin $display("FAIL seq_early: got %0b expected 0", seq); misses++; end
        drive(1'b1, 1'b0, 50);
        drive(1'b0, 1'b0, 5);
        vectors++; if (seq !== 1'b1) begin $display("FAIL seq_set: got %0b expected 1", seq); misses++; end
        vectors++; if (pulses - base !== 1) begin $display("FAIL seq_count: got %0d expected 1", pulses - base); misses++; end
        vectors++; if (period !== 10'd358) begin $display("FAIL seq_hold_period: got %0d expected 358", period); misses++; end
        vectors++; if (on_c1 !== 10'd200) begin $display("FAIL seq_hold_on_c1: got %0d expected 200", on_c1); misses++; end
    endtask

    task automatic test_reset_and_enable();
        int base;
        do_reset();
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        nominal_period();
        drive(1'b1, 1'b0, 200);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 50);
        vectors++; if (period !== 10'd358) begin $display("FAIL rst_pre_period: got %0d expected 358", period); misses++; end
        rst = 1'b1;
        #1;
        vectors++; if (period !== 10'd0) begin $display("FAIL rst_async_period: got %0d expected 0", period); misses++; end
        vectors++; if (on_c2 !== 10'd0) begin $display("FAIL rst_async_on_c2: got %0d expected 0", on_c2); misses++; end
        vectors++; if (dt_21 !== 10'd0) begin $display("FAIL rst_async_dt_21: got %0d expected 0", dt_21); misses++; end
        @(negedge clk);
        rst = 1'b0;
        c2  = 1'b0;
        drive(1'b0, 1'b0, 5);
        base = pulses;
        drive(1'b1, 1'b0, 200);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 80);
        en = 1'b0;
        drive(1'b0, 1'b1, 70);
        drive(1'b0, 1'b0, 5);
        en = 1'b1;
        drive(1'b0, 1'b0, 5);
        nominal_period();
        vectors++; if (pulses - base !== 0) begin $display("FAIL en_abort: got %0d expected 0", pulses - base); misses++; end
        drive(1'b1, 1'b0, 10);
        vectors++; if (pulses - base !== 1) begin $display("FAIL en_second_rise: got %0d expected 1", pulses - base); misses++; end
        vectors++; if (lp !== 358) begin $display("FAIL en_period: got %0d expected 358", lp); misses++; end
        vectors++; if (l_dt21 !== 5) begin $display("FAIL en_dt_21: got %0d expected 5", l_dt21); misses++; end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_zero_deadtime();
        test_overlap();
        test_timeout();
        test_seq_fault();
        test_reset_and_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
